// File: rtl/sys_bus_ctrl.sv
// System bus controller: registered address decode, read mux, per-slot wait states, interrupt controller.
// Optional macro SYS_BUS_ERRLOG_EN adds unmapped-access logging (ERRADDR, PENDING[7]) in an 8-byte CSR window.
module sys_bus_ctrl #(
    parameter int unsigned             N_SLOTS   = 4,
    parameter logic [16*N_SLOTS-1:0]   SLOT_BASE = {16'h8000, 16'h6000, 16'h5000, 16'h0000},
    parameter logic [16*N_SLOTS-1:0]   SLOT_MASK = {16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000},
    parameter logic [4*N_SLOTS-1:0]    SLOT_WAIT = {4'd0, 4'd0, 4'd0, 4'd0},
    parameter int unsigned             N_IRQ     = 8,
    parameter logic [15:0]             CSR_BASE  = 16'h5F00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            cpu_addr,
    input  logic                   cpu_we,
    input  logic [7:0]             cpu_do,
    output logic [7:0]             cpu_di,
    output logic                   cpu_rdy,
    output logic                   cpu_irq,
    output logic [15:0]            slot_addr,
    output logic [N_SLOTS-1:0]     slot_cs,
    output logic                   slot_we,
    input  logic [8*N_SLOTS-1:0]   slot_rdata,
    input  logic [N_IRQ-1:0]       irq_in
);

`ifdef SYS_BUS_ERRLOG_EN
    localparam int unsigned CSR_AW = 3;
`else
    localparam int unsigned CSR_AW = 2;
`endif
    localparam logic [7:0] IRQ_VALID = 8'((16'd1 << N_IRQ) - 16'd1);
`ifdef SYS_BUS_ERRLOG_EN
    localparam logic [7:0] MASK_VALID = IRQ_VALID | 8'h80;
`else
    localparam logic [7:0] MASK_VALID = IRQ_VALID;
`endif

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        csr_hit;
    logic [2:0]  csr_off;
    logic        slot_hit;
    logic [7:0]  slot_rd;
    logic [3:0]  slot_wait;
    logic [7:0]  csr_rd;
    logic [7:0]  irq_ext;
    logic [7:0]  irq_q;
    logic [7:0]  pending, pending_next;
    logic [7:0]  mask;
    logic [7:0]  set_vec;
    logic [7:0]  ack_vec;
    logic        csr_wr;
    logic        unmapped;
`ifdef SYS_BUS_ERRLOG_EN
    logic [15:0] erraddr;
`endif

    assign irq_ext  = 8'(irq_in);
    assign csr_hit  = (slot_addr[15:CSR_AW] == CSR_BASE[15:CSR_AW]);
    assign csr_off  = 3'(slot_addr[CSR_AW-1:0]);
    assign unmapped = !csr_hit && !slot_hit;

    // Lowest-index matching region wins; the CSR window shadows every slot.
    always_comb begin
        slot_cs   = '0;
        slot_hit  = 1'b0;
        slot_rd   = 8'hFF;
        slot_wait = 4'd0;
        if (!csr_hit) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                if (!slot_hit && ((slot_addr & SLOT_MASK[16*i +: 16]) == SLOT_BASE[16*i +: 16])) begin
                    slot_hit   = 1'b1;
                    slot_cs[i] = 1'b1;
                    slot_rd    = slot_rdata[8*i +: 8];
                    slot_wait  = SLOT_WAIT[4*i +: 4];
                end
            end
        end
    end

    always_comb begin
        csr_rd = 8'h00;
        case (csr_off)
            3'd0:    csr_rd = pending;
            3'd1:    csr_rd = mask;
            3'd3:    csr_rd = irq_ext;
`ifdef SYS_BUS_ERRLOG_EN
            3'd4:    csr_rd = erraddr[7:0];
            3'd5:    csr_rd = erraddr[15:8];
`endif
            default: csr_rd = 8'h00;
        endcase
    end

    assign cpu_di  = csr_hit ? csr_rd : slot_rd;
    assign slot_we = cpu_we && cpu_rdy && slot_hit;
    assign csr_wr  = cpu_we && cpu_rdy && csr_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Stall is W cycles: the IDLE cycle that loads the counter plus WAIT cycles until it hits 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cpu_rdy    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (slot_hit && (slot_wait != 4'd0)) begin
                    cpu_rdy    = 1'b0;
                    cnt_next   = slot_wait;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = ST_IDLE;
                end else begin
                    cpu_rdy = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A new edge in the same cycle as its acknowledge keeps the pending bit set.
    always_comb begin
        set_vec = irq_ext & ~irq_q & IRQ_VALID;
`ifdef SYS_BUS_ERRLOG_EN
        set_vec[7] = unmapped;
`endif
        ack_vec      = (csr_wr && (csr_off == 3'd2)) ? (cpu_do & MASK_VALID) : 8'h00;
        pending_next = (pending & ~ack_vec) | set_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_addr <= 16'h0000;
            irq_q     <= 8'h00;
            pending   <= 8'h00;
            mask      <= 8'h00;
            cpu_irq   <= 1'b0;
`ifdef SYS_BUS_ERRLOG_EN
            erraddr   <= 16'h0000;
`endif
        end else begin
            if (cpu_rdy) begin
                slot_addr <= cpu_addr;
            end
            irq_q   <= irq_ext;
            pending <= pending_next;
            if (csr_wr && (csr_off == 3'd1)) begin
                mask <= cpu_do & MASK_VALID;
            end
            cpu_irq <= |(pending & mask);
`ifdef SYS_BUS_ERRLOG_EN
            if (unmapped && !pending[7]) begin
                erraddr <= slot_addr;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Bench for sys_bus_ctrl: decode table, directed wait/irq/reset sequences, randomized run against a reference model.
module tb_sys_bus_ctrl;

    localparam logic [15:0] BASE  [4] = '{16'h0000, 16'h5000, 16'h6000, 16'h8000};
    localparam logic [15:0] MASKS [4] = '{16'hC000, 16'hFFF0, 16'hFFF0, 16'h8000};
    localparam int          WAITS [4] = '{0, 0, 1, 3};

    logic        clk, rst;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_do, cpu_di;
    logic        cpu_rdy, cpu_irq;
    logic [15:0] slot_addr;
    logic [3:0]  slot_cs;
    logic        slot_we;
    logic [31:0] slot_rdata;
    logic [7:0]  irq_in;

    sys_bus_ctrl #(
        .N_SLOTS  (4),
        .SLOT_BASE({16'h8000, 16'h6000, 16'h5000, 16'h0000}),
        .SLOT_MASK({16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000}),
        .SLOT_WAIT({4'd3, 4'd1, 4'd0, 4'd0}),
        .N_IRQ    (8),
        .CSR_BASE (16'h5F00)
    ) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_irq(cpu_irq), .slot_addr(slot_addr),
        .slot_cs(slot_cs), .slot_we(slot_we), .slot_rdata(slot_rdata), .irq_in(irq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: access lasts W+1 cycles with the first W stalled; irq state kept as plain bytes.
    logic [15:0] m_addr;
    int          m_acc;
    logic [7:0]  m_pend, m_mask, m_prev;
    logic        m_irq;

    typedef struct packed {
        logic [3:0] cs;
        logic [7:0] di;
        logic       rdy;
        logic       we;
    } exp_t;

    function automatic bit is_csr(input logic [15:0] a);
        return (a >= 16'h5F00) && (a <= 16'h5F03);
    endfunction

    task automatic model_reset();
        m_addr = 16'h0000; m_acc = 0; m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00; m_irq = 1'b0;
    endtask

    function automatic exp_t model_eval();
        exp_t e;
        int   hit;
        int   off;
        hit = -1;
        e.cs = 4'b0000; e.di = 8'hFF; e.rdy = 1'b1; e.we = 1'b0;
        if (is_csr(m_addr)) begin
            off = int'(m_addr - 16'h5F00);
            case (off)
                0:       e.di = m_pend;
                1:       e.di = m_mask;
                3:       e.di = irq_in;
                default: e.di = 8'h00;
            endcase
        end else begin
            for (int i = 0; i < 4; i++)
                if (hit < 0 && (m_addr & MASKS[i]) == BASE[i]) hit = i;
            if (hit >= 0) begin
                e.cs  = 4'(1 << hit);
                e.di  = slot_rdata[8*hit +: 8];
                e.rdy = (WAITS[hit] == 0) || (m_acc == WAITS[hit]);
                e.we  = cpu_we && e.rdy;
            end
        end
        return e;
    endfunction

    task automatic model_step(input exp_t e);
        logic [7:0] ack;
        logic [7:0] new_mask;
        ack = 8'h00;
        new_mask = m_mask;
        if (e.rdy && cpu_we && is_csr(m_addr)) begin
            if (m_addr == 16'h5F01) new_mask = cpu_do;
            if (m_addr == 16'h5F02) ack = cpu_do;
        end
        m_irq  = |(m_pend & m_mask);
        m_pend = (m_pend & ~ack) | (irq_in & ~m_prev);
        m_prev = irq_in;
        m_mask = new_mask;
        if (e.rdy) begin
            m_addr = cpu_addr;
            m_acc  = 0;
        end else begin
            m_acc++;
        end
    endtask

    // One clock: compare all outputs with the model mid low phase, then advance the model at the edge.
    task automatic cycle();
        exp_t e;
        #1;
        e = model_eval();
        chk("m_cs",   32'(slot_cs),   32'(e.cs));
        chk("m_di",   32'(cpu_di),    32'(e.di));
        chk("m_rdy",  32'(cpu_rdy),   32'(e.rdy));
        chk("m_we",   32'(slot_we),   32'(e.we));
        chk("m_irq",  32'(cpu_irq),   32'(m_irq));
        chk("m_addr", 32'(slot_addr), 32'(m_addr));
        @(posedge clk);
        model_step(e);
        @(negedge clk);
    endtask

    task automatic access(input logic [15:0] a, input logic we, input logic [7:0] d,
                          output logic [7:0] rd);
        int k;
        cpu_addr = a; cpu_we = 1'b0;
        cycle();
        cpu_we = we; cpu_do = d;
        for (k = 0; k < 20; k++) begin
            #1;
            if (cpu_rdy) break;
            cycle();
        end
        chk("access_done", 32'(k < 20), 32'd1);
        rd = cpu_di;
        cpu_addr = 16'h0000;
        cycle();
        cpu_we = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  cs;
        logic [7:0]  di;
        logic        rdy;
    } vec_t;

    vec_t        tbl [11];
    logic [7:0]  rd;
    int          st;
    int          k;
    logic [15:0] cur;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{16'h8003, 4'b1000, 8'hA9, 1'b0};
        tbl[1]  = '{16'h0000, 4'b0001, 8'h17, 1'b1};
        tbl[2]  = '{16'h3FFF, 4'b0001, 8'h17, 1'b1};
        tbl[3]  = '{16'h5000, 4'b0010, 8'h3E, 1'b1};
        tbl[4]  = '{16'h500F, 4'b0010, 8'h3E, 1'b1};
        tbl[5]  = '{16'h5010, 4'b0000, 8'hFF, 1'b1};
        tbl[6]  = '{16'h4000, 4'b0000, 8'hFF, 1'b1};
        tbl[7]  = '{16'h6005, 4'b0100, 8'h5C, 1'b0};
        tbl[8]  = '{16'hFFFF, 4'b1000, 8'hA9, 1'b0};
        tbl[9]  = '{16'h5F03, 4'b0000, 8'h00, 1'b1};
        tbl[10] = '{16'h5F04, 4'b0000, 8'hFF, 1'b1};

        rst = 1'b1; cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_do = 8'h00;
        slot_rdata = 32'hA95C3E17; irq_in = 8'h00;
        model_reset();
        #2;
        chk("rst_rdy",  32'(cpu_rdy),   32'd1);
        chk("rst_irq",  32'(cpu_irq),   32'd0);
        chk("rst_addr", 32'(slot_addr), 32'h0000);
        chk("rst_cs",   32'(slot_cs),   32'b0001);
        chk("rst_di",   32'(cpu_di),    32'h17);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Decode table: outputs in the first cycle of each access, then let the access complete.
        for (int i = 0; i < 11; i++) begin
            cpu_addr = tbl[i].addr;
            cycle();
            #1;
            chk("tbl_cs",  32'(slot_cs), 32'(tbl[i].cs));
            chk("tbl_di",  32'(cpu_di),  32'(tbl[i].di));
            chk("tbl_rdy", 32'(cpu_rdy), 32'(tbl[i].rdy));
            cpu_addr = 16'h0000;
            for (k = 0; k < 20 && !cpu_rdy; k++) cycle();
            chk("tbl_drain", 32'(k < 20), 32'd1);
            cycle();
        end

        // Back-to-back reads of the 3-wait ROM slot.
        cpu_addr = 16'h8003;
        cycle();
        for (int a = 0; a < 2; a++) begin
            st = 0;
            cur = 16'h8003 + 16'(a);
            for (k = 0; k < 20; k++) begin
                #1;
                if (cpu_rdy) break;
                st++;
                chk("stall_addr", 32'(slot_addr), 32'(cur));
                chk("stall_we",   32'(slot_we),   32'd0);
                cycle();
            end
            chk("stall_count", 32'(st), 32'd3);
            cpu_addr = (a == 0) ? 16'h8004 : 16'h0000;
            cycle();
        end

        // Mask, pending, irq latency and acknowledge.
        access(16'h5F01, 1'b1, 8'h05, rd);
        irq_in = 8'h04;
        cycle();
        irq_in = 8'h00;
        #1 chk("irq_lat0", 32'(cpu_irq), 32'd0);
        cycle();
        #1 chk("irq_set", 32'(cpu_irq), 32'd1);
        access(16'h5F00, 1'b0, 8'h00, rd);
        chk("pend_04", 32'(rd), 32'h04);
        access(16'h5F01, 1'b0, 8'h00, rd);
        chk("mask_05", 32'(rd), 32'h05);
        access(16'h5F02, 1'b1, 8'h04, rd);
        #1 chk("irq_hold", 32'(cpu_irq), 32'd1);
        cycle();
        #1 chk("irq_clr", 32'(cpu_irq), 32'd0);
        access(16'h5F00, 1'b0, 8'h00, rd);
        chk("pend_clr", 32'(rd), 32'h00);

        // Rising edge in the same cycle as its acknowledge.
        cpu_addr = 16'h5F02;
        cycle();
        cpu_we = 1'b1; cpu_do = 8'h01; irq_in = 8'h01;
        cpu_addr = 16'h0000;
        cycle();
        cpu_we = 1'b0;
        access(16'h5F00, 1'b0, 8'h00, rd);
        chk("set_wins", 32'(rd), 32'h01);
        irq_in = 8'h00;
        access(16'h5F02, 1'b1, 8'h01, rd);
        access(16'h5F00, 1'b0, 8'h00, rd);
        chk("ack_after", 32'(rd), 32'h00);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 5))
                0:       cpu_addr = 16'($urandom);
                1:       cpu_addr = 16'h5F00 + 16'($urandom_range(0, 7));
                2:       cpu_addr = 16'h8000 | 16'($urandom);
                3:       cpu_addr = 16'h5000 + 16'($urandom_range(0, 31));
                4:       cpu_addr = 16'h6000 + 16'($urandom_range(0, 31));
                default: cpu_addr = 16'($urandom) & 16'h3FFF;
            endcase
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_do     = 8'($urandom);
            slot_rdata = $urandom;
            if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
            cycle();
        end
        cpu_we = 1'b0; irq_in = 8'h00; cpu_addr = 16'h0000;
        for (k = 0; k < 20 && !cpu_rdy; k++) cycle();
        chk("rand_drain", 32'(k < 20), 32'd1);
        cycle();
        access(16'h5F02, 1'b1, 8'hFF, rd);

        // Asynchronous reset in the middle of a stall.
        access(16'h5F01, 1'b1, 8'hFF, rd);
        irq_in = 8'h02;
        cycle();
        irq_in = 8'h00;
        cpu_addr = 16'h8003;
        cycle();
        cycle();
        cycle();
        #1;
        chk("pre_rst_rdy", 32'(cpu_rdy), 32'd0);
        chk("pre_rst_irq", 32'(cpu_irq), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy",  32'(cpu_rdy),   32'd1);
        chk("mid_rst_addr", 32'(slot_addr), 32'h0000);
        chk("mid_rst_irq",  32'(cpu_irq),   32'd0);
        model_reset();
        cpu_addr = 16'h0000;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        access(16'h5F01, 1'b0, 8'h00, rd);
        chk("post_rst_mask", 32'(rd), 32'h00);
        access(16'h5F00, 1'b0, 8'h00, rd);
        chk("post_rst_pend", 32'(rd), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
